// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, m_tuser flag layout and baud divider maths.
// Latency: n/a (package).
// Backpressure: n/a (package).
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    localparam int PAR_ERR = 0;
    localparam int FRM_ERR = 1;
    localparam int BRK     = 2;

    // Field order matches the PAR_ERR/FRM_ERR/BRK bit indices.
    typedef struct packed {
        logic brk;
        logic frm_err;
        logic par_err;
    } flags_t;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_mhz, input int bit_rate, input int ovs);
        longint num;
        longint den;
        num = longint'(clk_mhz) * longint'(1000000);
        den = longint'(bit_rate) * longint'(ovs);
        return int'((num + den / 2) / den);
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with registered head-of-queue output and occupancy count.
// Latency: a push into an empty FIFO is visible on out_vld the next cycle.
// Backpressure: in_rdy drops when full unless a pop happens in the same cycle.
module axis_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     in_vld,
    input  logic [WIDTH-1:0]         in_dat,
    output logic                     in_rdy,
    output logic                     out_vld,
    output logic [WIDTH-1:0]         out_dat,
    input  logic                     out_rdy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt;
    logic             pop;
    logic             push;

    assign pop    = out_vld && out_rdy;
    assign in_rdy = (count != FULL) || pop;
    assign push   = in_vld && in_rdy;
    assign rd_nxt = rd_ptr + 1'b1;

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // out_dat mirrors mem[rd_ptr]; it bypasses mem when the entry arrives this cycle.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (pop) begin
                if (count > ONE) begin
                    out_dat <= mem[rd_nxt];
                end else if (push) begin
                    out_dat <= in_dat;
                end
                out_vld <= (count > ONE) || push;
            end else if (!out_vld && push) begin
                out_dat <= in_dat;
                out_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ovs_axis.sv
// Oversampling UART receiver with 2-of-3 mid-bit voting, emitting words on AXI-Stream.
// Latency: word leaves on m_tvalid one cycle after the mid-point of its last stop bit.
// Backpressure: words queue in a FIFO; a word arriving while full and not popping is dropped with an overrun pulse.
module uart_rx_ovs_axis
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = 100,
    parameter int BIT_RATE      = 115200,
    parameter int BIT_PER_WORD  = 8,
    parameter int PARITY_BIT    = 0,
    parameter int STOP_BITS_NUM = 1,
    parameter int OVERSAMPLE    = 16,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          RX,
    output logic [BIT_PER_WORD-1:0]       m_tdata,
    output logic [2:0]                    m_tuser,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DIV = calc_div(CLK_FREQ, BIT_RATE, OVERSAMPLE);
    localparam int TW  = $clog2(DIV);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(BIT_PER_WORD);
    localparam parity_e PMODE = parity_e'(2'(PARITY_BIT));

    localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BIT_PER_WORD - 1);
    localparam logic          P_LAST = 1'(STOP_BITS_NUM - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH, WAIT_HIGH} state_t;

    state_t                  state, state_nxt;
    logic                    rx_meta, rx_s, rx_hi;
    logic [1:0]              fill;
    logic [TW-1:0]           tick_cnt;
    logic [SW-1:0]           samp_cnt;
    logic [1:0]              votes;
    logic [BW-1:0]           bit_cnt;
    logic                    stop_cnt;
    logic [BIT_PER_WORD-1:0] shreg;
    logic                    par_bit, frm_err, stop0_low;
    logic                    tick, mid, wrap, vote, fall, push, fifo_in_rdy;
    flags_t                  flags;

    // rx_hi only follows real samples, so a line held low through reset never looks like a fresh edge.
    assign fall = rx_hi && !rx_s;
    assign tick = (tick_cnt == T_LAST);
    assign mid  = tick && (samp_cnt == S_V2);
    assign wrap = tick && (samp_cnt == S_LAST);
    assign vote = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);

    always_comb begin
        flags.par_err = 1'b0;
        if (PMODE == ODD) begin
            flags.par_err = ~(^shreg ^ par_bit);
        end else if (PMODE == EVEN) begin
            flags.par_err = ^shreg ^ par_bit;
        end
        flags.frm_err = frm_err;
        flags.brk     = (shreg == '0) && ((PMODE == NONE) || !par_bit) && stop0_low;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE:      if (fall) state_nxt = START;
            START: begin
                if (mid && vote) state_nxt = IDLE;
                else if (wrap)   state_nxt = DATA;
            end
            DATA:      if (wrap && bit_cnt == B_LAST) state_nxt = (PMODE != NONE) ? PARITY : STOP;
            PARITY:    if (wrap) state_nxt = STOP;
            STOP:      if (mid && stop_cnt == P_LAST) state_nxt = PUSH;
            PUSH: begin
                push      = 1'b1;
                state_nxt = frm_err ? WAIT_HIGH : IDLE;
            end
            WAIT_HIGH: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_hi     <= 1'b0;
            fill      <= 2'b00;
            tick_cnt  <= '0;
            samp_cnt  <= '0;
            votes     <= 2'b00;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            frm_err   <= 1'b0;
            stop0_low <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
            fill    <= {fill[0], 1'b1};
            if (fill[1]) rx_hi <= rx_s;

            if (state == IDLE || state_nxt == IDLE || tick) tick_cnt <= '0;
            else                                            tick_cnt <= tick_cnt + 1'b1;

            if (state == IDLE)  samp_cnt <= '0;
            else if (tick)      samp_cnt <= (samp_cnt == S_LAST) ? '0 : samp_cnt + 1'b1;

            if (tick && samp_cnt == S_V0) votes[0] <= rx_s;
            if (tick && samp_cnt == S_V1) votes[1] <= rx_s;

            if (state == IDLE && fall) begin
                bit_cnt   <= '0;
                stop_cnt  <= 1'b0;
                frm_err   <= 1'b0;
                stop0_low <= 1'b0;
            end
            if (state == DATA && mid)  shreg   <= {vote, shreg[BIT_PER_WORD-1:1]};
            if (state == DATA && wrap) bit_cnt <= bit_cnt + 1'b1;
            if (state == PARITY && mid) par_bit <= vote;
            if (state == STOP && mid) begin
                if (!vote)     frm_err   <= 1'b1;
                if (!stop_cnt) stop0_low <= !vote;
            end
            if (state == STOP && wrap) stop_cnt <= 1'b1;

            overrun <= push && !fifo_in_rdy;
        end
    end

    logic [BIT_PER_WORD+2:0] out_dat;

    axis_sync_fifo #(
        .WIDTH (BIT_PER_WORD + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .in_vld  (push),
        .in_dat  ({flags, shreg}),
        .in_rdy  (fifo_in_rdy),
        .out_vld (m_tvalid),
        .out_dat (out_dat),
        .out_rdy (m_tready),
        .count   (fifo_count)
    );

    assign m_tdata = out_dat[BIT_PER_WORD-1:0];
    assign m_tuser = out_dat[BIT_PER_WORD+:3];

endmodule

// File: tb/tb_uart_rx_ovs_axis.sv
// Directed bench for uart_rx_ovs_axis (8N1 and 8E1 instances at 100 MHz / 115200 / x16).
// Expected beats come from a frame-level model queue fed alongside the line stimulus.
module tb_uart_rx_ovs_axis;
    localparam int BIT_CYC = 864;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       rx, rx_e;
    logic [7:0] m_tdata, e_tdata;
    logic [2:0] m_tuser, e_tuser;
    logic       m_tvalid, e_tvalid;
    logic       m_tready, e_tready;
    logic       overrun, e_ovr;
    logic [4:0] fifo_count, e_count;

    always #5 aclk = ~aclk;

    uart_rx_ovs_axis #(
        .CLK_FREQ(100), .BIT_RATE(115200), .BIT_PER_WORD(8), .PARITY_BIT(0),
        .STOP_BITS_NUM(1), .OVERSAMPLE(16), .FIFO_DEPTH(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .RX(rx), .m_tdata(m_tdata), .m_tuser(m_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .overrun(overrun), .fifo_count(fifo_count)
    );

    uart_rx_ovs_axis #(
        .CLK_FREQ(100), .BIT_RATE(115200), .BIT_PER_WORD(8), .PARITY_BIT(2),
        .STOP_BITS_NUM(1), .OVERSAMPLE(16), .FIFO_DEPTH(16)
    ) dut_e (
        .aclk(aclk), .aresetn(aresetn), .RX(rx_e), .m_tdata(e_tdata), .m_tuser(e_tuser),
        .m_tvalid(e_tvalid), .m_tready(e_tready), .overrun(e_ovr), .fifo_count(e_count)
    );

    int          checks = 0;
    int          errors = 0;
    logic [10:0] exp_q[$];
    logic [10:0] exp_e[$];
    int          beats = 0, e_beats = 0, ovr_seen = 0, exp_ovr = 0;
    logic [7:0]  last_dat, e_last_dat;
    logic [2:0]  last_user, e_last_user;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Flags a receiver must report for a frame driven with the given line levels.
    function automatic logic [2:0] frame_flags(input logic [7:0] d, input int pmode,
                                               input logic pbit, input logic stop);
        logic perr, brk;
        perr = (pmode == 1) ? ~(^d ^ pbit) : (pmode == 2) ? (^d ^ pbit) : 1'b0;
        brk  = (d == 8'h00) && (pmode == 0 || !pbit) && !stop;
        return {brk, !stop || brk, perr};
    endfunction

    task automatic model_push(input logic [7:0] d, input logic [2:0] f);
        if (exp_q.size() >= 16 && !m_tready) exp_ovr++;
        else                                 exp_q.push_back({f, d});
    endtask

    task automatic send_frame(input bit sel_e, input logic [7:0] d, input bit has_par,
                              input logic pbit, input logic stop);
        bit b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (has_par) b.push_back(pbit);
        b.push_back(stop);
        foreach (b[i]) begin
            if (sel_e) rx_e = b[i];
            else       rx   = b[i];
            repeat (BIT_CYC) @(negedge aclk);
        end
    endtask

    // Compare process: every handshake and every stalled cycle of both instances.
    initial begin
        logic       prev_hold = 1'b0;
        logic [7:0] prev_dat;
        logic [2:0] prev_user;
        logic [10:0] e;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_hold = 1'b0;
            end else begin
                if (overrun) ovr_seen++;
                if (prev_hold) begin
                    checks++;
                    if (!m_tvalid || m_tdata !== prev_dat || m_tuser !== prev_user) begin
                        errors++;
                        $display("FAIL hold_stable actual=%b/%0h/%0h required=1/%0h/%0h",
                                 m_tvalid, m_tdata, m_tuser, prev_dat, prev_user);
                    end
                end
                prev_hold = m_tvalid && !m_tready;
                prev_dat  = m_tdata;
                prev_user = m_tuser;
                if (m_tvalid && m_tready) begin
                    beats++;
                    last_dat  = m_tdata;
                    last_user = m_tuser;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat actual=%0h/%0h required=none", m_tuser, m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_tuser, m_tdata} !== e) begin
                            errors++;
                            $display("FAIL beat actual=%0h/%0h required=%0h/%0h",
                                     m_tuser, m_tdata, e[10:8], e[7:0]);
                        end
                    end
                end
                if (e_tvalid && e_tready) begin
                    e_beats++;
                    e_last_dat  = e_tdata;
                    e_last_user = e_tuser;
                    checks++;
                    if (exp_e.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat_e actual=%0h/%0h required=none", e_tuser, e_tdata);
                    end else begin
                        e = exp_e.pop_front();
                        if ({e_tuser, e_tdata} !== e) begin
                            errors++;
                            $display("FAIL beat_e actual=%0h/%0h required=%0h/%0h",
                                     e_tuser, e_tdata, e[10:8], e[7:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rx = 1'b0; rx_e = 1'b1; m_tready = 1'b1; e_tready = 1'b1; aresetn = 1'b0;
        repeat (4) @(negedge aclk);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tuser", m_tuser, 0);
        chk("rst_overrun", overrun | e_ovr, 0);
        chk("rst_count", fifo_count, 0);

        // Line low through reset must not start a frame.
        aresetn = 1'b1;
        repeat (2000) @(negedge aclk);
        rx = 1'b1;
        repeat (12 * BIT_CYC) @(negedge aclk);
        chk("held_low_beats", beats, 0);
        chk("held_low_count", fifo_count, 0);

        // 0xA5, with m_tvalid timed from the start-bit edge.
        model_push(8'hA5, frame_flags(8'hA5, 0, 1'b0, 1'b1));
        fork
            send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                n = 0;
                while (!m_tvalid && n < 20000) begin
                    @(negedge aclk);
                    n++;
                end
                chk("a5_latency", n, 8320);
            end
        join
        chk("a5_data", last_dat, 8'hA5);
        chk("a5_user", last_user, 3'b000);

        // 3-cycle glitch is a false start; a normal frame follows.
        rx = 1'b0;
        repeat (3) @(negedge aclk);
        rx = 1'b1;
        repeat (12 * BIT_CYC) @(negedge aclk);
        chk("glitch_beats", beats, 1);
        chk("glitch_tvalid", m_tvalid, 0);
        model_push(8'h96, frame_flags(8'h96, 0, 1'b0, 1'b1));
        send_frame(1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
        repeat (BIT_CYC) @(negedge aclk);
        chk("after_glitch_data", last_dat, 8'h96);

        // Break: low for two frame times.
        model_push(8'h00, frame_flags(8'h00, 0, 1'b0, 1'b0));
        rx = 1'b0;
        repeat (20 * BIT_CYC) @(negedge aclk);
        chk("break_beats_low", beats, 3);
        rx = 1'b1;
        repeat (12 * BIT_CYC) @(negedge aclk);
        chk("break_beats_high", beats, 3);
        chk("break_data", last_dat, 8'h00);
        chk("break_user", last_user, 3'b110);

        // 8E1 frame 0x03 with the parity bit wrong.
        exp_e.push_back({frame_flags(8'h03, 2, 1'b1, 1'b1), 8'h03});
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        repeat (BIT_CYC) @(negedge aclk);
        chk("par_beats", e_beats, 1);
        chk("par_data", e_last_dat, 8'h03);
        chk("par_user", e_last_user, 3'b001);

        // Reset inside the data bits of 0x5A, then 0x3C.
        rx = 1'b0; repeat (BIT_CYC) @(negedge aclk);
        rx = 1'b0; repeat (BIT_CYC) @(negedge aclk);
        rx = 1'b1; repeat (BIT_CYC) @(negedge aclk);
        rx = 1'b0; repeat (BIT_CYC) @(negedge aclk);
        rx = 1'b1; repeat (400) @(negedge aclk);
        aresetn = 1'b0;
        repeat (5) @(negedge aclk);
        aresetn = 1'b1;
        chk("midrst_tvalid", m_tvalid, 0);
        chk("midrst_count", fifo_count, 0);
        repeat (12 * BIT_CYC) @(negedge aclk);
        chk("midrst_beats", beats, 3);
        model_push(8'h3C, frame_flags(8'h3C, 0, 1'b0, 1'b1));
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (BIT_CYC) @(negedge aclk);
        chk("midrst_next_beats", beats, 4);
        chk("midrst_next_data", last_dat, 8'h3C);

        // Overflow: 17 frames with the sink stalled.
        @(posedge aclk); #1 m_tready = 1'b0;
        @(negedge aclk);
        for (int i = 0; i < 17; i++) begin
            model_push(8'(i), frame_flags(8'(i), 0, 1'b0, 1'b1));
            send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
        end
        chk("ovf_count", fifo_count, 16);
        chk("ovf_pulses", ovr_seen, exp_ovr);
        chk("ovf_pulses_one", ovr_seen, 1);
        chk("ovf_head", {m_tvalid, m_tdata}, {1'b1, 8'h00});
        @(posedge aclk); #1 m_tready = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge aclk);
            if (!m_tvalid) break;
            n++;
        end
        chk("drain_run", n, 16);
        chk("drain_count", fifo_count, 0);
        chk("drain_beats", beats, 20);
        chk("model_empty", exp_q.size() + exp_e.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
